// File: rtl/fft_frame_src.sv
// Ping-pong frame source for the radix-2 FFT: buffers offset-binary ADC samples as signed complex
// words and streams one per req cycle. Define FFT_SRC_IQ_EN to add the quadrature input adc_data_q.
module fft_frame_src #(
  parameter int SIZE  = 256,
  parameter int RN    = 16,
  parameter int DN    = 12,
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [DN-1:0]        adc_data,
`ifdef FFT_SRC_IQ_EN
  input  logic [DN-1:0]        adc_data_q,
`endif
  input  logic                 adc_valid,
  input  logic                 req,
  output logic signed [RN-1:0] out [2],
  output logic                 primed,
  output logic                 frame_start,
  output logic                 overrun,
  output logic                 underrun
);

  localparam int AW = $clog2(SIZE);
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_MAX  = {AW{1'b1}};
  localparam logic [RN-1:0] WORD_ZERO = {RN{1'b0}};

  typedef enum logic [0:0] {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_t;

  typedef enum logic [2:0] {
    RD_EMPTY  = 3'd0,
    RD_PRIME  = 3'd1,
    RD_PRIMED = 3'd2,
    RD_BURST  = 3'd3,
    RD_SKIP   = 3'd4
  } rd_state_t;

  function automatic logic signed [RN-1:0] conv(input logic [DN-1:0] d);
    logic signed [DN-1:0] s;
    logic signed [RN-1:0] e;
    s = {~d[DN-1], d[DN-2:0]};
    e = RN'(s);
    return e <<< SHIFT;
  endfunction

  logic [2*RN-1:0] mem_r [2*SIZE];

  wr_state_t wr_state_r, wr_state_s;
  logic      wr_bank_r, wr_bank_s;
  logic [AW-1:0] wr_idx_r, wr_idx_s;
  logic      wr_en_s, set_ready_s, overrun_s, other_free_s;
  logic [2*RN-1:0] wr_data_s;

  rd_state_t rd_state_r, rd_state_s;
  logic      rd_bank_r, rd_bank_s;
  logic [AW-1:0] rd_idx_r, rd_idx_s, rd_addr_idx_s;
  logic      rd_load_s, out_zero_s, clr_ready_s, rd_active_s, burst_start_s;
  logic      primed_s, frame_start_s, underrun_s;

  logic [1:0] ready_r, ready_s;
  logic       prev_req_r;
  logic signed [RN-1:0] out_r [2];
  logic       primed_r, frame_start_r, overrun_r, underrun_r;

`ifdef FFT_SRC_IQ_EN
  assign wr_data_s = {conv(adc_data_q), conv(adc_data)};
`else
  assign wr_data_s = {WORD_ZERO, conv(adc_data)};
`endif

  assign burst_start_s = req & ~prev_req_r;
  assign rd_active_s   = (rd_state_r == RD_PRIME) || (rd_state_r == RD_PRIMED) ||
                         (rd_state_r == RD_BURST);
  // A bank being read is always marked ready; the second term only guards that invariant
  assign other_free_s  = ~ready_r[~wr_bank_r] & ~(rd_active_s & (rd_bank_r == ~wr_bank_r));

  // Writer FSM: fill the current bank, then hop banks or stall in WAIT
  always_comb begin
    wr_state_s  = wr_state_r;
    wr_bank_s   = wr_bank_r;
    wr_idx_s    = wr_idx_r;
    wr_en_s     = 1'b0;
    set_ready_s = 1'b0;
    overrun_s   = 1'b0;
    case (wr_state_r)
      WR_FILL: begin
        if (adc_valid) begin
          wr_en_s = 1'b1;
          if (wr_idx_r == IDX_MAX) begin
            set_ready_s = 1'b1;
            wr_idx_s    = IDX_ZERO;
            if (other_free_s) begin
              wr_bank_s = ~wr_bank_r;
            end else begin
              wr_state_s = WR_WAIT;
            end
          end else begin
            wr_idx_s = wr_idx_r + IDX_ONE;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      WR_WAIT: begin
        overrun_s = adc_valid;
        if (other_free_s) begin
          wr_bank_s  = ~wr_bank_r;
          wr_idx_s   = IDX_ZERO;
          wr_state_s = WR_FILL;
        end else begin
          wr_state_s = WR_WAIT;
        end
      end
      default: begin
        wr_state_s = WR_FILL;
        wr_idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Reader FSM: prime sample 0, stream a frame per burst, swallow bursts with nothing primed
  always_comb begin
    rd_state_s    = rd_state_r;
    rd_bank_s     = rd_bank_r;
    rd_idx_s      = rd_idx_r;
    rd_addr_idx_s = IDX_ZERO;
    rd_load_s     = 1'b0;
    out_zero_s    = 1'b0;
    clr_ready_s   = 1'b0;
    primed_s      = primed_r;
    frame_start_s = 1'b0;
    underrun_s    = 1'b0;
    case (rd_state_r)
      RD_EMPTY: begin
        out_zero_s = 1'b1;
        primed_s   = 1'b0;
        if (burst_start_s) begin
          underrun_s = 1'b1;
          rd_state_s = RD_SKIP;
        end else if (ready_r[rd_bank_r]) begin
          rd_state_s = RD_PRIME;
        end else begin
          rd_state_s = RD_EMPTY;
        end
      end
      RD_PRIME: begin
        if (burst_start_s) begin
          underrun_s = 1'b1;
          out_zero_s = 1'b1;
          rd_state_s = RD_SKIP;
        end else begin
          rd_load_s     = 1'b1;
          rd_addr_idx_s = IDX_ZERO;
          rd_idx_s      = IDX_ZERO;
          primed_s      = 1'b1;
          rd_state_s    = RD_PRIMED;
        end
      end
      RD_PRIMED: begin
        if (burst_start_s) begin
          frame_start_s = 1'b1;
          rd_load_s     = 1'b1;
          rd_addr_idx_s = IDX_ONE;
          rd_idx_s      = IDX_ONE;
          rd_state_s    = RD_BURST;
        end else begin
          rd_state_s = RD_PRIMED;
        end
      end
      RD_BURST: begin
        if (req) begin
          if (rd_idx_r == IDX_MAX) begin
            clr_ready_s = 1'b1;
            rd_bank_s   = ~rd_bank_r;
            primed_s    = 1'b0;
            out_zero_s  = 1'b1;
            rd_state_s  = RD_EMPTY;
          end else begin
            rd_load_s     = 1'b1;
            rd_addr_idx_s = rd_idx_r + IDX_ONE;
            rd_idx_s      = rd_idx_r + IDX_ONE;
          end
        end else begin
          // Burst cut short: the rest of this frame is stale, free the bank
          clr_ready_s = 1'b1;
          rd_bank_s   = ~rd_bank_r;
          primed_s    = 1'b0;
          out_zero_s  = 1'b1;
          underrun_s  = 1'b1;
          rd_state_s  = RD_EMPTY;
        end
      end
      RD_SKIP: begin
        out_zero_s = 1'b1;
        if (!req) begin
          rd_state_s = RD_EMPTY;
        end else begin
          rd_state_s = RD_SKIP;
        end
      end
      default: begin
        out_zero_s = 1'b1;
        primed_s   = 1'b0;
        rd_state_s = RD_EMPTY;
      end
    endcase
  end

  // Ready flags: writer sets its bank, reader clears its bank (never the same bank)
  always_comb begin
    ready_s = ready_r;
    for (int b = 0; b < 2; b++) begin
      ready_s[b] = (ready_r[b] | (set_ready_s & (wr_bank_r == 1'(b)))) &
                   ~(clr_ready_s & (rd_bank_r == 1'(b)));
    end
  end

  // Sample RAM write port; contents are never read before being written
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, wr_idx_r}] <= wr_data_s;
    end
  end

  // Output word register doubles as the synchronous RAM read register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_r[0] <= WORD_ZERO;
      out_r[1] <= WORD_ZERO;
    end else if (rd_load_s) begin
      out_r[0] <= $signed(mem_r[{rd_bank_r, rd_addr_idx_s}][RN-1:0]);
      out_r[1] <= $signed(mem_r[{rd_bank_r, rd_addr_idx_s}][2*RN-1:RN]);
    end else if (out_zero_s) begin
      out_r[0] <= WORD_ZERO;
      out_r[1] <= WORD_ZERO;
    end
  end

  // State, index and flag registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_state_r    <= WR_FILL;
      wr_bank_r     <= 1'b0;
      wr_idx_r      <= IDX_ZERO;
      rd_state_r    <= RD_EMPTY;
      rd_bank_r     <= 1'b0;
      rd_idx_r      <= IDX_ZERO;
      ready_r       <= 2'b00;
      prev_req_r    <= 1'b0;
      primed_r      <= 1'b0;
      frame_start_r <= 1'b0;
      overrun_r     <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      wr_state_r    <= wr_state_s;
      wr_bank_r     <= wr_bank_s;
      wr_idx_r      <= wr_idx_s;
      rd_state_r    <= rd_state_s;
      rd_bank_r     <= rd_bank_s;
      rd_idx_r      <= rd_idx_s;
      ready_r       <= ready_s;
      prev_req_r    <= req;
      primed_r      <= primed_s;
      frame_start_r <= frame_start_s;
      overrun_r     <= overrun_s;
      underrun_r    <= underrun_s;
    end
  end

  assign out[0]      = out_r[0];
  assign out[1]      = out_r[1];
  assign primed      = primed_r;
  assign frame_start = frame_start_r;
  assign overrun     = overrun_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_fft_frame_src.sv
// Scoreboard bench for fft_frame_src (SIZE=256, DN=12, RN=16, SHIFT=2): stimulus pushes expected
// words, a negedge monitor pops and compares every req cycle and tallies the pulse outputs.
module tb_fft_frame_src;

  localparam int SIZE = 256;
`ifdef FFT_SRC_IQ_EN
  localparam int IM_EXP = -4;
`else
  localparam int IM_EXP = 0;
`endif

  logic              clk;
  logic              n_reset;
  logic [11:0]       adc_data;
  logic              adc_valid;
  logic              req;
  logic signed [15:0] out_w [2];
  logic              primed, frame_start, overrun, underrun;
`ifdef FFT_SRC_IQ_EN
  logic [11:0]       adc_data_q;
`endif

  fft_frame_src #(.SIZE(SIZE), .RN(16), .DN(12), .SHIFT(2)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .adc_data(adc_data),
`ifdef FFT_SRC_IQ_EN
    .adc_data_q(adc_data_q),
`endif
    .adc_valid(adc_valid),
    .req(req),
    .out(out_w),
    .primed(primed),
    .frame_start(frame_start),
    .overrun(overrun),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt = 0, ur_cnt = 0, ov_cnt = 0;
  int fs_exp = 0, ur_exp = 0, ov_exp = 0;
  int exp_re_q[$];
  int exp_im_q[$];
  int frame_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected signed word for an offset-binary code: remove the 2048 offset, scale by 4
  function automatic int model(input logic [11:0] d);
    return (int'(d) - 2048) * 4;
  endfunction

  function automatic logic [11:0] pat(input int mode, input int i);
    logic [11:0] v;
    case (mode)
      0: v = 12'h800 + 12'(i);
      1: v = (i == 0) ? 12'h000 : ((i == 1) ? 12'hFFF : 12'hFFF - 12'(i));
      2: v = 12'(i * 7 + 291);
      default: v = 12'(i * 13 + 5);
    endcase
    return v;
  endfunction

  // Monitor: pulse tallies and scoreboard compare of every word consumed by req
  always @(negedge clk) begin
    if (n_reset) begin
      if (frame_start) fs_cnt++;
      if (underrun) ur_cnt++;
      if (overrun) ov_cnt++;
      if (req) begin
        if (exp_re_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          chk("out_real", int'(out_w[0]), exp_re_q.pop_front());
          chk("out_imag", int'(out_w[1]), exp_im_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic feed(input int mode, input int n, input int n_store);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = pat(mode, i);
      if (i < n_store) frame_q.push_back(model(pat(mode, i)));
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
  endtask

  // kind 0: full frame, 1: no frame (underrun), 2: partial frame of n then req drops
  task automatic burst(input int kind, input int n);
    int v;
    for (int k = 0; k < SIZE; k++) begin
      v = (kind == 1) ? 0 : frame_q.pop_front();
      if (k < n) begin
        exp_re_q.push_back(v);
        exp_im_q.push_back((kind == 1) ? 0 : IM_EXP);
      end
      if (kind == 1 && k + 1 >= n) break;
    end
    if (kind == 1) begin
      for (int k = n; k < SIZE; k++) frame_q.push_back(0);
      for (int k = n; k < SIZE; k++) void'(frame_q.pop_back());
    end
    for (int k = 0; k < n; k++) begin
      req = 1'b1;
      @(posedge clk); #1;
      if (k == 0) begin
        chk("frame_start_first", int'(frame_start), (kind == 1) ? 0 : 1);
        chk("underrun_first", int'(underrun), (kind == 1) ? 1 : 0);
      end
    end
    req = 1'b0;
    if (kind == 0) begin
      chk("primed_after_last", int'(primed), 0);
      fs_exp++;
    end else if (kind == 1) begin
      ur_exp++;
    end else begin
      @(posedge clk); #1;
      chk("underrun_on_drop", int'(underrun), 1);
      chk("primed_after_drop", int'(primed), 0);
      fs_exp++;
      ur_exp++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    n_reset   = 1'b0;
    adc_data  = 12'h000;
    adc_valid = 1'b0;
    req       = 1'b0;
`ifdef FFT_SRC_IQ_EN
    adc_data_q = 12'h7FF;
`endif
    idle(3);
    chk("reset_out_real", int'(out_w[0]), 0);
    chk("reset_out_imag", int'(out_w[1]), 0);
    chk("reset_primed", int'(primed), 0);
    chk("reset_pulses", int'({frame_start, overrun, underrun}), 0);
    n_reset = 1'b1;
    idle(2);
    chk("idle_primed", int'(primed), 0);

    // Ramp frame 0x800+i -> 4*i
    feed(0, SIZE, SIZE);
    idle(4);
    chk("ramp_primed", int'(primed), 1);
    burst(0, SIZE);
    idle(2);

    // Full-scale conversion
    feed(1, SIZE, SIZE);
    idle(4);
    chk("fullscale_primed", int'(primed), 1);
    chk("fullscale_neg", int'(out_w[0]), -8192);
    chk("fullscale_imag", int'(out_w[1]), IM_EXP);
    burst(0, SIZE);
    idle(2);

    // Burst with nothing primed, then a frame delivered on the next burst
    burst(1, SIZE);
    idle(2);
    chk("skip_out_zero", int'(out_w[0]), 0);
    feed(3, SIZE, SIZE);
    idle(4);
    burst(0, SIZE);
    idle(2);
    chk("fs_cnt_t3", fs_cnt, fs_exp);
    chk("ur_cnt_t3", ur_cnt, ur_exp);
    chk("ov_cnt_t3", ov_cnt, 0);

    // Both banks fill, the next ten samples overrun
    feed(2, 2 * SIZE + 10, 2 * SIZE);
    idle(2);
    ov_exp = 10;
    chk("ov_cnt_t4", ov_cnt, ov_exp);
    chk("t4_primed", int'(primed), 1);
    burst(0, SIZE);
    idle(2);
    feed(3, SIZE, SIZE);
    idle(4);
    burst(0, SIZE);
    idle(4);
    burst(0, SIZE);
    idle(2);
    chk("ov_cnt_t4_end", ov_cnt, ov_exp);

    // Burst cut after 100 consumes; next burst delivers the following frame from index 0
    feed(0, SIZE, SIZE);
    feed(2, SIZE, SIZE);
    idle(4);
    burst(2, 100);
    idle(4);
    chk("t5_primed", int'(primed), 1);
    burst(0, SIZE);
    idle(3);

    chk("fs_cnt_end", fs_cnt, fs_exp);
    chk("ur_cnt_end", ur_cnt, ur_exp);
    chk("ov_cnt_end", ov_cnt, ov_exp);
    chk("scoreboard_drained", exp_re_q.size(), 0);
    chk("frames_drained", frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
